// File: rtl/spm_ctrl_if.sv
// Request/response handshake bundle between the bus-side register block and spm_ctrl.
// The master drives requests and accepts products; the slave is the sequencer.
interface spm_ctrl_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_x;
   logic [WIDTH-1:0]   in_y;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_p;

   modport master (
      output in_valid, in_x, in_y, out_ready,
      input  in_ready, out_valid, out_p
   );

   modport slave (
      input  in_valid, in_x, in_y, out_ready,
      output in_ready, out_valid, out_p
   );
endinterface

// File: rtl/spm_ctrl.sv
// Sequencer for an external serial-parallel multiplier: clears it, streams y LSB-first
// with sign extension, and deserialises the 2*WIDTH-bit signed product.
module spm_ctrl #(
   parameter int unsigned  WIDTH = 32,
   localparam int unsigned CNT_W = $clog2(2*WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   spm_ctrl_if.slave        bus,
   output logic             busy,
   output logic             spm_rst,
   output logic [WIDTH-1:0] spm_x,
   output logic             spm_y,
   input  logic             spm_p
);

   typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   y_sr_q;
   logic [WIDTH-1:0]   y_asr;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [2*WIDTH-1:0] out_p_q;
   logic               busy_q;
   logic               spm_rst_q;
   logic [WIDTH-1:0]   spm_x_q;
   logic               spm_y_q;

   // Arithmetic shift keeps presenting the sign bit once all y bits have been sent.
   assign y_asr = {y_sr_q[WIDTH-1], y_sr_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         y_sr_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
         busy_q      <= 1'b0;
         spm_rst_q   <= 1'b1;
         spm_x_q     <= '0;
         spm_y_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               spm_rst_q <= 1'b0;
               if (bus.in_valid && in_ready_q) begin
                  spm_x_q    <= bus.in_x;
                  y_sr_q     <= bus.in_y;
                  spm_rst_q  <= 1'b1;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StClear;
               end
            end
            StClear: begin
               spm_rst_q <= 1'b0;
               cnt_q     <= '0;
               spm_y_q   <= y_sr_q[0];
               y_sr_q    <= y_asr;
               state_q   <= StRun;
            end
            StRun: begin
               cnt_q  <= cnt_q + CNT_W'(1);
               y_sr_q <= y_asr;
               // spm_p lags spm_y by one cycle, so nothing useful arrives in cycle 0.
               if (cnt_q != '0) begin
                  out_p_q <= {spm_p, out_p_q[2*WIDTH-1:1]};
               end
               // Final RUN cycle only flushes the last product bit; feed a zero.
               if (cnt_q >= CNT_W'(2*WIDTH-1)) begin
                  spm_y_q <= 1'b0;
               end else begin
                  spm_y_q <= y_sr_q[0];
               end
               if (cnt_q == CNT_W'(2*WIDTH)) begin
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_p     = out_p_q;
   assign busy          = busy_q;
   assign spm_rst       = spm_rst_q;
   assign spm_x         = spm_x_q;
   assign spm_y         = spm_y_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// Directed bench for spm_ctrl at WIDTH=8, driving a behavioural serial-parallel
// multiplier with one-cycle latency on the spm_* pins.
module tb_spm_ctrl;
   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         busy;
   logic         spm_rst;
   logic [W-1:0] spm_x;
   logic         spm_y;
   logic         spm_p;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   spm_ctrl_if #(.WIDTH(W)) bus ();

   spm_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .busy    (busy),
      .spm_rst (spm_rst),
      .spm_x   (spm_x),
      .spm_y   (spm_y),
      .spm_p   (spm_p)
   );

   // Multiplier model: running partial sum, one product bit out per cycle.
   logic signed [2*W+1:0] acc;
   logic signed [2*W+1:0] sum;
   always_comb sum = acc + (spm_y ? {{(W+2){spm_x[W-1]}}, spm_x} : '0);
   always @(posedge clk) begin
      if (spm_rst) begin
         acc   <= '0;
         spm_p <= 1'b0;
      end else begin
         acc   <= sum >>> 1;
         spm_p <= sum[0];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!bus.in_ready && n < 200) begin
         step();
         n++;
      end
      check({tag, "_ready_wait"}, 64'(n < 200), 64'd1);
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (!bus.out_valid && n < 200) begin
         step();
         n++;
      end
      check({tag, "_valid_wait"}, 64'(n < 200), 64'd1);
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] exp, input int hold, input string tag);
      int n  = 0;
      int rh = 0;
      bus.in_x     = x;
      bus.in_y     = y;
      bus.in_valid = 1'b1;
      wait_ready(tag);
      step();
      bus.in_valid = 1'b0;
      bus.in_x     = W'($urandom);
      bus.in_y     = W'($urandom);
      check({tag, "_spm_x"}, 64'(spm_x), 64'(x));
      while (!bus.out_valid && n < 200) begin
         rh += int'(spm_rst);
         step();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(2*W+2));
      check({tag, "_clear_cycles"}, 64'(rh), 64'd1);
      check({tag, "_out_p"}, 64'(bus.out_p), 64'(exp));
      bus.out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         step();
         check({tag, "_hold"}, 64'({bus.out_valid, bus.out_p, bus.in_ready}),
               64'({1'b1, exp, 1'b0}));
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({tag, "_drain"}, 64'({bus.out_valid, bus.in_ready, busy}), 64'(3'b010));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a1;
      int a2;
      int n;
      logic [W-1:0]          rx;
      logic [W-1:0]          ry;
      logic signed [2*W-1:0] xs;
      logic signed [2*W-1:0] ys;
      logic signed [2*W-1:0] pe;

      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.out_ready = 1'b0;
      rst           = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset_ctl", 64'({bus.in_ready, bus.out_valid, busy, spm_rst, spm_y}),
            64'(5'b10010));
      check("reset_out_p", 64'(bus.out_p), 64'd0);
      check("reset_spm_x", 64'(spm_x), 64'd0);
      step();
      step();
      rst = 1'b0;
      step();
      check("idle_spm_rst", 64'(spm_rst), 64'd0);

      run_op(8'd3,   8'd5,   16'h000F, 0,  "x3y5");
      run_op(8'hFF,  8'hFF,  16'h0001, 0,  "m1m1");
      run_op(8'h80,  8'h80,  16'h4000, 0,  "minmin");
      run_op(8'h7F,  8'h80,  16'hC080, 0,  "maxmin");
      run_op(8'hF9,  8'h0D,  16'hFFA5, 10, "bp");

      // Back-to-back with in_valid held and operands changing during RUN.
      bus.in_x      = 8'd2;
      bus.in_y      = 8'd3;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      wait_ready("b2b0");
      step();
      a1         = cyc;
      bus.in_x   = 8'hFC;
      bus.in_y   = 8'd6;
      wait_valid("b2b0", n);
      check("b2b0_out_p", 64'(bus.out_p), 64'h0006);
      wait_ready("b2b1");
      step();
      a2           = cyc;
      bus.in_valid = 1'b0;
      check("b2b_gap", 64'(a2 - a1), 64'(2*W+4));
      wait_valid("b2b1", n);
      check("b2b1_out_p", 64'(bus.out_p), 64'hFFE8);
      step();
      bus.out_ready = 1'b0;
      check("b2b_drain", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));

      // Reset asserted in RUN cycle 7.
      bus.in_x     = 8'd9;
      bus.in_y     = 8'd9;
      bus.in_valid = 1'b1;
      wait_ready("mid");
      step();
      bus.in_valid = 1'b0;
      step();
      repeat (7) step();
      check("mid_busy", 64'({busy, spm_rst, bus.out_valid}), 64'(3'b100));
      rst = 1'b1;
      #1;
      check("mid_rst_async", 64'({bus.in_ready, bus.out_valid, busy, spm_rst}), 64'(4'b1001));
      step();
      check("mid_rst_edge", 64'({bus.in_ready, bus.out_valid, busy, spm_rst}), 64'(4'b1001));
      check("mid_rst_out_p", 64'(bus.out_p), 64'd0);
      rst = 1'b0;
      run_op(8'd10, 8'd10, 16'h0064, 0, "post_rst");

      for (int i = 0; i < 20; i++) begin
         rx = W'($urandom);
         ry = W'($urandom);
         xs = $signed(rx);
         ys = $signed(ry);
         pe = xs * ys;
         run_op(rx, ry, pe, i % 3, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
